// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the uart_rx and uart_tx byte streams: echo, accumulate or drain.
// Optional macro ALU_SUB_EN enables the OP_SUB (first operand minus later operands) command.
module alu_packet_ctrl #(
    parameter int unsigned OPW     = 32,
    parameter logic [7:0]  OP_ECHO = 8'hEC,
    parameter logic [7:0]  OP_ADD  = 8'h01,
    parameter logic [7:0]  OP_SUB  = 8'h02
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_tdata_i,
    input  logic       rx_tvalid_i,
    output logic       rx_tready_o,
    output logic [7:0] tx_tdata_o,
    output logic       tx_tvalid_o,
    input  logic       tx_tready_i,
    output logic       busy_o,
    output logic       err_o
);
    localparam int unsigned NB  = OPW / 8;
    localparam int unsigned NBW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [NBW-1:0] LAST = NBW'(NB - 1);

    typedef enum logic [2:0] {S_HDR, S_ECHO, S_ACC, S_RES, S_DRAIN} state_t;

    state_t         state;
    logic [1:0]     hdr_cnt;
    logic [7:0]     opcode;
    logic [7:0]     len_lsb;
    logic [15:0]    byte_cnt;
    logic [NBW-1:0] byte_idx;
    logic [OPW-1:0] acc;
    logic [OPW-1:0] opnd;
    logic           live;
    logic           tv_r;
    logic [7:0]     td_r;
    logic           err_r;
`ifdef ALU_SUB_EN
    logic           first;
`endif

    logic           echo;
    logic           rx_fire;
    logic           tx_fire;
    logic           is_alu;
    logic [15:0]    len;
    logic [15:0]    plen;
    logic [OPW-1:0] opnd_full;
    logic [OPW-1:0] acc_nxt;

    // Echo is a straight combinational path; every other state drives from registers.
    assign echo        = (state == S_ECHO);
    assign rx_tready_o = echo ? tx_tready_i
                              : (live && (state == S_HDR || state == S_ACC || state == S_DRAIN));
    assign tx_tvalid_o = echo ? rx_tvalid_i : tv_r;
    assign tx_tdata_o  = echo ? rx_tdata_i  : td_r;
    assign busy_o      = (state != S_HDR) || (hdr_cnt != 2'd0);
    assign err_o       = err_r;

    assign rx_fire = rx_tvalid_i && rx_tready_o;
    assign tx_fire = tx_tvalid_o && tx_tready_i;

    assign len  = {rx_tdata_i, len_lsb};
    assign plen = (len < 16'd4) ? 16'd0 : len - 16'd4;

    // Operand shifts in from the top, so after NB bytes the first byte sits in bits 7:0.
    assign opnd_full = (opnd >> 8) | (OPW'(rx_tdata_i) << (OPW - 8));

`ifdef ALU_SUB_EN
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

    always_comb begin
        acc_nxt = acc + opnd_full;
        if (opcode == OP_SUB) begin
            acc_nxt = first ? opnd_full : acc - opnd_full;
        end
    end
`else
    // OP_SUB is rejected explicitly so it always falls into the unknown-opcode path.
    assign is_alu  = (opcode == OP_ADD) && (opcode != OP_SUB);
    assign acc_nxt = acc + opnd_full;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= S_HDR;
            hdr_cnt  <= '0;
            opcode   <= '0;
            len_lsb  <= '0;
            byte_cnt <= '0;
            byte_idx <= '0;
            acc      <= '0;
            opnd     <= '0;
            live     <= 1'b0;
            tv_r     <= 1'b0;
            td_r     <= '0;
            err_r    <= 1'b0;
`ifdef ALU_SUB_EN
            first    <= 1'b0;
`endif
        end else begin
            live  <= 1'b1;
            err_r <= 1'b0;
            case (state)
                S_HDR: begin
                    if (rx_fire) begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        case (hdr_cnt)
                            2'd0: opcode  <= rx_tdata_i;
                            2'd2: len_lsb <= rx_tdata_i;
                            2'd3: begin
                                byte_cnt <= plen;
                                byte_idx <= '0;
                                acc      <= '0;
`ifdef ALU_SUB_EN
                                first    <= 1'b1;
`endif
                                if (opcode == OP_ECHO) begin
                                    if (plen != 16'd0) state <= S_ECHO;
                                end else if (is_alu) begin
                                    if (plen == 16'd0) begin
                                        state <= S_RES;
                                        tv_r  <= 1'b1;
                                        td_r  <= '0;
                                    end else begin
                                        state <= S_ACC;
                                    end
                                end else begin
                                    err_r <= 1'b1;
                                    if (plen != 16'd0) state <= S_DRAIN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_ECHO: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) state <= S_HDR;
                    end
                end
                S_ACC: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt - 16'd1;
                        opnd     <= opnd_full;
                        if (byte_idx == LAST) begin
                            acc      <= acc_nxt;
                            byte_idx <= '0;
`ifdef ALU_SUB_EN
                            first    <= 1'b0;
`endif
                        end else begin
                            byte_idx <= byte_idx + NBW'(1);
                        end
                        // Last payload byte: present result byte 0 on the very next cycle.
                        if (byte_cnt == 16'd1) begin
                            state    <= S_RES;
                            tv_r     <= 1'b1;
                            byte_idx <= '0;
                            td_r     <= (byte_idx == LAST) ? acc_nxt[7:0] : acc[7:0];
                            if (byte_idx != LAST) err_r <= 1'b1;
                        end
                    end
                end
                S_RES: begin
                    if (tx_fire) begin
                        if (byte_idx == LAST) begin
                            state    <= S_HDR;
                            tv_r     <= 1'b0;
                            td_r     <= '0;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + NBW'(1);
                            td_r     <= 8'(acc >> {byte_idx + NBW'(1), 3'b000});
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) state <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end
endmodule
